// File: rtl/ds_buf_arb.sv
// ds_buf_arb: RAM ownership arbiter (DMA writer vs TDSP reader) with ping-pong half-buffer sequencing.
// Optional starvation guard for DMA is compiled in with `define DS_ARB_STARVE_GUARD_EN.
module ds_buf_arb #(
    parameter int ADDR_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_breq,
    output logic              dma_grant,
    input  logic              dma_wr_done,
    output logic [ADDR_W-1:0] dma_addr,
    input  logic              tdsp_breq,
    output logic              tdsp_grant,
    input  logic              tdsp_buf_ack,
    output logic              top_buf_flag,
    output logic              buf_ready,
    output logic              buf_pending,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CNT_W = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, DMA_OWN, TDSP_OWN, HANDOFF} state_t;

    state_t            state, state_nxt;
    logic              last_rel_dma;
    logic              preempt;
    logic [CNT_W-1:0]  sample_cnt;
    logic              wr_cnt;
    logic              wrap;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dma_breq)       state_nxt = DMA_OWN;
                else if (tdsp_breq) state_nxt = TDSP_OWN;
            end
            DMA_OWN: begin
                if (!dma_breq) state_nxt = HANDOFF;
            end
            TDSP_OWN: begin
                if (!tdsp_breq || preempt) state_nxt = HANDOFF;
            end
            HANDOFF: begin
                // On a tie the side that just released yields to the other one.
                if (dma_breq && tdsp_breq) state_nxt = last_rel_dma ? TDSP_OWN : DMA_OWN;
                else if (dma_breq)         state_nxt = DMA_OWN;
                else if (tdsp_breq)        state_nxt = TDSP_OWN;
                else                       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are registered from the current state, so each handoff leaves one cycle with both low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_rel_dma <= 1'b0;
            dma_grant    <= 1'b0;
            tdsp_grant   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dma_grant  <= (state == DMA_OWN);
            tdsp_grant <= (state == TDSP_OWN);
            if (state == DMA_OWN && state_nxt == HANDOFF)
                last_rel_dma <= 1'b1;
            else if (state == TDSP_OWN && state_nxt == HANDOFF)
                last_rel_dma <= 1'b0;
        end
    end

`ifdef DS_ARB_STARVE_GUARD_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= '0;
        else if (state_nxt == TDSP_OWN && state != TDSP_OWN)
            hold_cnt <= '0;
        else if (state == TDSP_OWN && dma_breq && hold_cnt != HOLD_W'(MAX_HOLD))
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    assign preempt = dma_breq && (hold_cnt == HOLD_W'(MAX_HOLD));
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
    assign preempt         = 1'b0;
`endif

    assign wr_cnt   = dma_wr_done && dma_grant;
    assign wrap     = wr_cnt && (sample_cnt == {CNT_W{1'b1}});
    assign dma_addr = {top_buf_flag, sample_cnt};

    // Half-buffer sequencing: an ack on the wrap cycle retires the old half, the new one stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt   <= '0;
            top_buf_flag <= 1'b0;
            buf_ready    <= 1'b0;
            buf_pending  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            buf_ready <= wrap;
            if (wrap) begin
                sample_cnt   <= '0;
                top_buf_flag <= ~top_buf_flag;
                buf_pending  <= 1'b1;
            end else begin
                if (wr_cnt)
                    sample_cnt <= sample_cnt + 1'b1;
                if (tdsp_buf_ack)
                    buf_pending <= 1'b0;
            end
            if (wrap && buf_pending && !tdsp_buf_ack)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ds_buf_arb.sv
// Scoreboard bench for ds_buf_arb: stimulus queues cycle-tagged expectations and buf_ready events,
// a negedge monitor pops and compares them.
module tb_ds_buf_arb;

    localparam int ADDR_W = 8;

    localparam int DG   = 0;
    localparam int TG   = 1;
    localparam int ADDR = 2;
    localparam int FLAG = 3;
    localparam int RDY  = 4;
    localparam int PEND = 5;
    localparam int OVR  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              dma_breq;
    logic              dma_grant;
    logic              dma_wr_done;
    logic [ADDR_W-1:0] dma_addr;
    logic              tdsp_breq;
    logic              tdsp_grant;
    logic              tdsp_buf_ack;
    logic              top_buf_flag;
    logic              buf_ready;
    logic              buf_pending;
    logic              overrun;
    logic              ovr_clr;

    ds_buf_arb #(.ADDR_W(ADDR_W), .MAX_HOLD(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .dma_breq     (dma_breq),
        .dma_grant    (dma_grant),
        .dma_wr_done  (dma_wr_done),
        .dma_addr     (dma_addr),
        .tdsp_breq    (tdsp_breq),
        .tdsp_grant   (tdsp_grant),
        .tdsp_buf_ack (tdsp_buf_ack),
        .top_buf_flag (top_buf_flag),
        .buf_ready    (buf_ready),
        .buf_pending  (buf_pending),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    logic rdy_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] obs(int sig);
        case (sig)
            DG:      return {7'd0, dma_grant};
            TG:      return {7'd0, tdsp_grant};
            ADDR:    return dma_addr;
            FLAG:    return {7'd0, top_buf_flag};
            RDY:     return {7'd0, buf_ready};
            PEND:    return {7'd0, buf_pending};
            OVR:     return {7'd0, overrun};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic expect_sig(input int d, input int sig, input logic [7:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic expect_zero(input int d, input string name);
        for (int s = DG; s <= OVR; s++) expect_sig(d, s, 8'h00, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: buf_ready events and cycle-tagged expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (buf_ready === 1'b1) begin
                n_cmp++;
                if (rdy_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_buf_ready cyc=%0d got flag=%b, no pulse expected", cyc, top_buf_flag);
                end else begin
                    logic ef;
                    ef = rdy_q.pop_front();
                    if (top_buf_flag !== ef) begin
                        n_bad++;
                        $display("FAIL ready_flag cyc=%0d got %b expected %b", cyc, top_buf_flag, ef);
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    n_cmp++;
                    if (obs(exp_q[i].sig) !== exp_q[i].val) begin
                        n_bad++;
                        $display("FAIL %s cyc=%0d sig=%0d got 0x%02h expected 0x%02h",
                                 exp_q[i].name, cyc, exp_q[i].sig, obs(exp_q[i].sig), exp_q[i].val);
                    end
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got no finish, expected end of stimulus", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; dma_breq = 1'b0; dma_wr_done = 1'b0;
        tdsp_breq = 1'b0; tdsp_buf_ack = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        expect_zero(0, "reset_state");

        // Simultaneous requests: DMA wins, one dead cycle on handoff.
        reset = 1'b0; dma_breq = 1'b1; tdsp_breq = 1'b1;
        expect_sig(1, DG, 8'h00, "dg_latency_early");
        expect_sig(2, DG, 8'h01, "dg_latency");
        expect_sig(2, TG, 8'h00, "tg_loses_tie");
        tick(); tick();
        dma_breq = 1'b0;
        expect_sig(1, DG, 8'h01, "dg_release_lag");
        expect_sig(2, DG, 8'h00, "dg_released");
        expect_sig(2, TG, 8'h00, "dead_cycle");
        expect_sig(3, TG, 8'h01, "tg_after_handoff");
        expect_sig(3, DG, 8'h00, "dg_off_in_tdsp");
        tick(); tick(); tick();

        // Writes without grant are ignored.
        dma_wr_done = 1'b1;
        tick(); tick(); tick();
        dma_wr_done = 1'b0;
        expect_sig(1, ADDR, 8'h00, "addr_no_grant");
        tick();

        dma_breq = 1'b1;
`ifdef DS_ARB_STARVE_GUARD_EN
        expect_sig(17, TG, 8'h01, "tg_before_preempt");
        expect_sig(18, TG, 8'h00, "tg_preempted");
        expect_sig(18, DG, 8'h00, "preempt_dead_cycle");
        expect_sig(19, DG, 8'h01, "dg_after_preempt");
        repeat (17) tick();
        tdsp_breq = 1'b0;
        tick(); tick();
`else
        expect_sig(30, TG, 8'h01, "tg_holds");
        expect_sig(30, DG, 8'h00, "dg_waits");
        repeat (30) tick();
        tdsp_breq = 1'b0;
        expect_sig(1, TG, 8'h01, "tg_release_lag");
        expect_sig(2, TG, 8'h00, "tg_released");
        expect_sig(2, DG, 8'h00, "release_dead_cycle");
        expect_sig(3, DG, 8'h01, "dg_after_release");
        repeat (3) tick();
`endif

        // 256 granted writes with no ack: two wraps, overrun on the second.
        dma_wr_done = 1'b1;
        for (int j = 1; j <= 256; j++) expect_sig(j, ADDR, 8'(j % 256), "addr_step");
        expect_sig(127, PEND, 8'h00, "pend_before_wrap");
        expect_sig(127, FLAG, 8'h00, "flag_before_wrap");
        expect_sig(128, FLAG, 8'h01, "flag_first_wrap");
        expect_sig(128, RDY,  8'h01, "ready_first_wrap");
        expect_sig(129, RDY,  8'h00, "ready_one_cycle");
        expect_sig(128, PEND, 8'h01, "pend_first_wrap");
        expect_sig(128, OVR,  8'h00, "no_ovr_first_wrap");
        expect_sig(255, OVR,  8'h00, "no_ovr_before_second");
        expect_sig(256, OVR,  8'h01, "ovr_second_wrap");
        expect_sig(256, FLAG, 8'h00, "flag_second_wrap");
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b0);
        repeat (256) tick();

        dma_wr_done = 1'b0; ovr_clr = 1'b1;
        expect_sig(1, OVR,  8'h00, "ovr_cleared");
        expect_sig(1, PEND, 8'h01, "pend_kept");
        tick();
        ovr_clr = 1'b0;

        // Ack coinciding with the wrap: no overrun, new half pending.
        dma_wr_done = 1'b1;
        repeat (127) tick();
        tdsp_buf_ack = 1'b1;
        expect_sig(1, OVR,  8'h00, "ack_wrap_no_ovr");
        expect_sig(1, PEND, 8'h01, "ack_wrap_pend");
        expect_sig(1, ADDR, 8'h80, "ack_wrap_addr");
        expect_sig(1, RDY,  8'h01, "ack_wrap_ready");
        rdy_q.push_back(1'b1);
        tick();
        dma_wr_done = 1'b0;
        expect_sig(1, PEND, 8'h00, "pend_acked");
        tick();
        expect_sig(1, PEND, 8'h00, "ack_when_clear");
        expect_sig(1, OVR,  8'h00, "ovr_still_clear");
        tick();
        tdsp_buf_ack = 1'b0;

        // Fill to 0x45 in the low half, then reset mid-half.
        dma_wr_done = 1'b1;
        expect_sig(128, FLAG, 8'h00, "flag_third_wrap");
        expect_sig(128, PEND, 8'h01, "pend_third_wrap");
        expect_sig(128, OVR,  8'h00, "no_ovr_after_ack");
        expect_sig(197, ADDR, 8'h45, "addr_mid_half");
        rdy_q.push_back(1'b0);
        repeat (197) tick();
        dma_wr_done = 1'b0; reset = 1'b1;
        expect_zero(1, "reset_mid_half");
        tick();
        reset = 1'b0;
        expect_sig(2, DG,   8'h01, "dg_after_reset");
        expect_sig(2, ADDR, 8'h00, "addr_after_reset");
        repeat (4) tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expectations got %0d left, expected 0", exp_q.size());
        end
        n_cmp++;
        if (rdy_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_buf_ready got %0d left, expected 0", rdy_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
